// File: rtl/mips_lite_pkg.sv
// Shared types for the MIPS-Lite front end.
//   word_t        : 32-bit machine word
//   INSTR_BYTES   : size of one instruction in bytes
//   fetch_entry_t : instruction word tagged with its PC
//   word_align()  : clears the byte-offset bits of an address
package mips_lite_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_entry_t;

   // Masking (rather than concatenating a slice) keeps every input bit referenced.
   function automatic word_t word_align(input word_t addr);
      return addr & ~word_t'(INSTR_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries between the memory response port and decode.
//   clk, reset     : clock, synchronous active-high reset
//   push/push_entry: write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the queue; wins over push and pop
//   count          : number of valid entries
//   head_valid     : queue not empty
//   head_entry     : oldest entry, zero when empty
module fetch_queue
   import mips_lite_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic             head_valid,
   output fetch_entry_t     head_entry
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != FULL_CNT) || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the head output is gated by validity instead.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count      = count_q;
   assign head_valid = (count_q != '0);
   assign head_entry = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS-Lite instruction fetch stage.
//   clk, reset            : clock, synchronous active-high reset
//   imem_req_*            : word-aligned fetch requests (valid/ready)
//   imem_rsp_*            : in-order instruction responses, no backpressure
//   redirect_valid/_pc    : branch/jump target from execute; squashes wrong path
//   instr_valid/_ready    : head-of-queue handshake to decode
//   pc, instr             : head instruction and its PC (zero when empty)
module mips_fetch_unit
   import mips_lite_pkg::*;
#(
   parameter word_t RESET_PC        = 32'h0000_0000,
   parameter int    QUEUE_DEPTH     = 4,
   parameter int    MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

   localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
   localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(QUEUE_DEPTH);
   localparam word_t            PC_STEP   = word_t'(INSTR_BYTES);

   word_t            fetch_pc_q, fetch_pc_d;
   word_t            rsp_pc_q, rsp_pc_d;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic [OUT_W-1:0] drop_q, drop_d;

   logic [CNT_W-1:0] q_count;
   logic             q_head_valid;
   fetch_entry_t     q_head;
   fetch_entry_t     push_entry;
   logic [SUM_W-1:0] credit_used;
   logic             req_fire, rsp_fire, rsp_keep, rsp_drop;
   word_t            redirect_target;

   // Queue slots are reserved at request time, so a response always has room.
   assign credit_used    = SUM_W'(q_count) + SUM_W'(outstanding_q);
   assign imem_req_valid = !reset && !redirect_valid &&
                           (outstanding_q < MAX_OUT) && (credit_used < DEPTH_SUM);
   assign imem_req_addr  = fetch_pc_q;

   assign req_fire        = imem_req_valid && imem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_fire        = imem_rsp_valid && (outstanding_q != '0);
   assign rsp_drop        = rsp_fire && (drop_q != '0);
   assign rsp_keep        = rsp_fire && (drop_q == '0);
   assign redirect_target = word_align(redirect_pc);

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;

      if (req_fire && !rsp_fire) begin
         outstanding_d = outstanding_q + OUT_W'(1);
      end else if (rsp_fire && !req_fire) begin
         outstanding_d = outstanding_q - OUT_W'(1);
      end

      if (redirect_valid) begin
         fetch_pc_d = redirect_target;
         rsp_pc_d   = redirect_target;
         // Every request still in flight after this edge belongs to the old path.
         drop_d     = outstanding_q - OUT_W'(rsp_fire);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end
         if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + PC_STEP;
         end
         if (rsp_drop) begin
            drop_d = drop_q - OUT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

   fetch_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (rsp_keep && !redirect_valid),
      .push_entry(push_entry),
      .pop       (q_head_valid && instr_ready),
      .flush     (redirect_valid),
      .count     (q_count),
      .head_valid(q_head_valid),
      .head_entry(q_head)
   );

   assign instr_valid = q_head_valid;
   assign pc          = q_head.pc;
   assign instr       = q_head.instr;

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;
   import mips_lite_pkg::*;

   localparam word_t RESET_PC = 32'h0000_0000;
   localparam word_t MAGIC    = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] pc;
   logic [31:0] instr;

   int vectors = 0;
   int miscompares = 0;

   mips_fetch_unit #(
      .RESET_PC(RESET_PC), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc(pc), .instr(instr)
   );

   always #5 clk = ~clk;

   // Fixed-latency in-order memory: data = address ^ MAGIC, cleared by reset.
   logic [1:0] lat_sel = 2'd0;
   logic       pv [4];
   word_t      pa [4];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
      end else begin
         for (int i = 3; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
         end
         pv[0] <= imem_req_valid && imem_req_ready;
         pa[0] <= imem_req_addr;
      end
   end

   always_comb begin
      imem_rsp_valid = pv[lat_sel];
      imem_rsp_data  = pa[lat_sel] ^ MAGIC;
   end

   task automatic do_reset(input int lat_i, input logic rdy);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      instr_ready    = rdy;
      lat_sel        = 2'(lat_i - 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b1; lat_sel = 2'd0;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got req_valid=%0b instr_valid=%0b pc=%h instr=%h, want 0 0 0 0",
                  imem_req_valid, instr_valid, pc, instr);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         miscompares++;
         $display("FAIL reset_first_req: got valid=%0b addr=%h, want 1 %h",
                  imem_req_valid, imem_req_addr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      word_t exp_req = RESET_PC;
      word_t exp_pc  = RESET_PC;
      do_reset(1, 1'b1);
      for (int k = 0; k < 12; k++) begin
         vectors++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_req) begin
            miscompares++;
            $display("FAIL stream_req k=%0d: got valid=%0b addr=%h, want 1 %h",
                     k, imem_req_valid, imem_req_addr, exp_req);
         end
         exp_req += 4;
         vectors++;
         if (k >= 2) begin
            if (instr_valid !== 1'b1 || pc !== exp_pc || instr !== (exp_pc ^ MAGIC)) begin
               miscompares++;
               $display("FAIL stream_instr k=%0d: got v=%0b pc=%h instr=%h, want 1 %h %h",
                        k, instr_valid, pc, instr, exp_pc, exp_pc ^ MAGIC);
            end
            exp_pc += 4;
         end else if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_early k=%0d: got instr_valid=%0b, want 0", k, instr_valid);
         end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_stall();
      int    reqs = 0;
      int    got = 0;
      int    cyc = 0;
      word_t exp_pc = RESET_PC;
      word_t exp_req = RESET_PC + 32'h10;
      do_reset(1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (imem_req_valid && imem_req_ready) reqs++;
         if (k >= 2) begin
            vectors++;
            if (instr_valid !== 1'b1 || pc !== RESET_PC) begin
               miscompares++;
               $display("FAIL stall_hold k=%0d: got v=%0b pc=%h, want 1 %h", k, instr_valid, pc, RESET_PC);
            end
         end
         @(negedge clk); #1;
      end
      vectors++;
      if (reqs != 4 || imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_credit: got reqs=%0d req_valid=%0b, want 4 0", reqs, imem_req_valid);
      end
      instr_ready = 1'b1;
      #1;
      while (got < 6 && cyc < 20) begin
         if (imem_req_valid && imem_req_ready) begin
            vectors++;
            if (imem_req_addr !== exp_req) begin
               miscompares++;
               $display("FAIL stall_req: got addr=%h, want %h", imem_req_addr, exp_req);
            end
            exp_req += 4;
         end
         if (instr_valid) begin
            vectors++;
            if (pc !== exp_pc || instr !== (exp_pc ^ MAGIC)) begin
               miscompares++;
               $display("FAIL stall_drain: got pc=%h instr=%h, want %h %h", pc, instr, exp_pc, exp_pc ^ MAGIC);
            end
            exp_pc += 4;
            got++;
         end
         cyc++;
         @(negedge clk); #1;
      end
      vectors++;
      if (got != 6) begin
         miscompares++;
         $display("FAIL stall_drain_count: got %0d instrs, want 6", got);
      end
   endtask

   task automatic test_redirect_inflight();
      int    got = 0;
      int    cyc = 0;
      bit    seen_req = 1'b0;
      word_t exp_pc = 32'h100;
      do_reset(3, 1'b1);
      @(negedge clk); @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_block_req: got req_valid=%0b, want 0", imem_req_valid);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      vectors++;
      if (instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_flushed: got instr_valid=%0b, want 0", instr_valid);
      end
      while (got < 2 && cyc < 20) begin
         if (imem_req_valid && imem_req_ready && !seen_req) begin
            seen_req = 1'b1;
            vectors++;
            if (imem_req_addr !== 32'h100) begin
               miscompares++;
               $display("FAIL redir_first_req: got addr=%h, want 00000100", imem_req_addr);
            end
         end
         if (instr_valid) begin
            vectors++;
            if (pc !== exp_pc || instr !== (exp_pc ^ MAGIC)) begin
               miscompares++;
               $display("FAIL redir_instr: got pc=%h instr=%h, want %h %h", pc, instr, exp_pc, exp_pc ^ MAGIC);
            end
            exp_pc += 4;
            got++;
         end
         cyc++;
         @(negedge clk); #1;
      end
      vectors++;
      if (got != 2) begin
         miscompares++;
         $display("FAIL redir_timeout: got %0d instrs, want 2", got);
      end
   endtask

   task automatic test_redirect_same_cycle();
      do_reset(1, 1'b1);
      repeat (4) @(negedge clk);
      #1;
      vectors++;
      if (instr_valid !== 1'b1 || pc !== 32'h8) begin
         miscompares++;
         $display("FAIL same_head: got v=%0b pc=%h, want 1 00000008", instr_valid, pc);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL same_block_req: got req_valid=%0b, want 0", imem_req_valid);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL same_next: got req_v=%0b addr=%h instr_v=%0b, want 1 00000200 0",
                  imem_req_valid, imem_req_addr, instr_valid);
      end
      @(negedge clk); #1;
      vectors++;
      if (instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL same_stale: got instr_valid=%0b pc=%h, want 0", instr_valid, pc);
      end
      @(negedge clk); #1;
      vectors++;
      if (instr_valid !== 1'b1 || pc !== 32'h200 || instr !== (32'h200 ^ MAGIC)) begin
         miscompares++;
         $display("FAIL same_target: got v=%0b pc=%h instr=%h, want 1 00000200 %h",
                  instr_valid, pc, instr, 32'h200 ^ MAGIC);
      end
   endtask

   task automatic test_wrap();
      int    got = 0;
      int    cyc = 0;
      word_t exp_req = 32'hFFFF_FFFC;
      word_t exp_pc  = 32'hFFFF_FFFC;
      do_reset(1, 1'b1);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      while (got < 3 && cyc < 20) begin
         if (cyc < 3) begin
            vectors++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_req) begin
               miscompares++;
               $display("FAIL wrap_req: got v=%0b addr=%h, want 1 %h", imem_req_valid, imem_req_addr, exp_req);
            end
            exp_req += 4;
         end
         if (instr_valid) begin
            vectors++;
            if (pc !== exp_pc || instr !== (exp_pc ^ MAGIC)) begin
               miscompares++;
               $display("FAIL wrap_instr: got pc=%h instr=%h, want %h %h", pc, instr, exp_pc, exp_pc ^ MAGIC);
            end
            exp_pc += 4;
            got++;
         end
         cyc++;
         @(negedge clk); #1;
      end
      vectors++;
      if (got != 3) begin
         miscompares++;
         $display("FAIL wrap_timeout: got %0d instrs, want 3", got);
      end
   endtask

   task automatic test_back_to_back();
      int    got = 0;
      int    cyc = 0;
      bit    seen_req = 1'b0;
      word_t exp_pc = 32'h400;
      do_reset(3, 1'b1);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      @(negedge clk);
      redirect_pc    = 32'h400;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      while (got < 2 && cyc < 25) begin
         if (imem_req_valid && imem_req_ready && !seen_req) begin
            seen_req = 1'b1;
            vectors++;
            if (imem_req_addr !== 32'h400) begin
               miscompares++;
               $display("FAIL b2b_first_req: got addr=%h, want 00000400", imem_req_addr);
            end
         end
         if (instr_valid) begin
            vectors++;
            if (pc !== exp_pc || instr !== (exp_pc ^ MAGIC)) begin
               miscompares++;
               $display("FAIL b2b_instr: got pc=%h instr=%h, want %h %h", pc, instr, exp_pc, exp_pc ^ MAGIC);
            end
            exp_pc += 4;
            got++;
         end
         cyc++;
         @(negedge clk); #1;
      end
      vectors++;
      if (got != 2) begin
         miscompares++;
         $display("FAIL b2b_timeout: got %0d instrs, want 2", got);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1, 1'b0);
      repeat (4) @(negedge clk);
      #1;
      vectors++;
      if (instr_valid !== 1'b1 || pc !== RESET_PC) begin
         miscompares++;
         $display("FAIL rmid_pre: got v=%0b pc=%h, want 1 %h", instr_valid, pc, RESET_PC);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_req_in_reset: got req_valid=%0b, want 0", imem_req_valid);
      end
      @(negedge clk); #1;
      vectors++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
         miscompares++;
         $display("FAIL rmid_cleared: got instr_v=%0b req_v=%0b pc=%h instr=%h, want 0 0 0 0",
                  instr_valid, imem_req_valid, pc, instr);
      end
      reset = 1'b0;
      instr_ready = 1'b1;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         miscompares++;
         $display("FAIL rmid_restart: got v=%0b addr=%h, want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (instr_valid !== 1'b1 || pc !== RESET_PC || instr !== (RESET_PC ^ MAGIC)) begin
         miscompares++;
         $display("FAIL rmid_first_instr: got v=%0b pc=%h instr=%h, want 1 %h %h",
                  instr_valid, pc, instr, RESET_PC, RESET_PC ^ MAGIC);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_inflight();
      test_redirect_same_cycle();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
